seq_detector_prog: RTL

//  Programmable serial pattern detector; parametrised successor of the fixed 4-bit "1011" detector.

---
 rtl/seq_detector_prog.sv | 103 ++++++++++
 1 files changed

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector with overlap control and a saturating match counter.
// One bit per valid cycle; z pulses one cycle after the final pattern bit is sampled.
module seq_detector_prog #(
    parameter int                   MAX_LEN     = 8,
    parameter int                   CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]   RST_PATTERN = MAX_LEN'(4'b1011),
    parameter int                   RST_LEN     = 4,
    parameter bit                   RST_OVERLAP = 1'b1,
    localparam int                  LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                x,
    input  logic                in_valid,
    input  logic                load,
    input  logic [MAX_LEN-1:0]  cfg_pattern,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic                cfg_overlap,
    output logic                z,
    output logic [CNT_W-1:0]    match_count,
    output logic                count_sat,
    output logic                cfg_err
);

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    // The oldest history bit would only ever be shifted out, so it is not stored.
    logic [MAX_LEN-2:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic               z_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sat_q;
    logic               err_q;

    logic [MAX_LEN-1:0] hist_d;
    logic [LEN_W-1:0]   fill_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [MAX_LEN-1:0] len_mask;
    logic               cfg_ok;
    logic               hit;

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        hist_d = {hist_q, x};
        fill_d = (fill_q == MAX_LEN_C) ? fill_q : fill_q + 1'b1;
        hit    = in_valid && !load && (fill_d >= len_q) &&
                 (((hist_d ^ pattern_q) & len_mask) == '0);
        cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        cfg_ok = (cfg_len != '0) && (cfg_len <= MAX_LEN_C);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= RST_PATTERN;
            len_q     <= LEN_W'(RST_LEN);
            ovl_q     <= RST_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            z_q       <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            z_q   <= 1'b0;
            err_q <= 1'b0;
            if (load) begin
                // A load always swallows the bit on x, accepted or not.
                if (cfg_ok) begin
                    pattern_q <= cfg_pattern;
                    len_q     <= cfg_len;
                    ovl_q     <= cfg_overlap;
                    hist_q    <= '0;
                    fill_q    <= '0;
                    cnt_q     <= '0;
                    sat_q     <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (in_valid) begin
                hist_q <= hist_d[MAX_LEN-2:0];
                fill_q <= (hit && !ovl_q) ? '0 : fill_d;
                z_q    <= hit;
                if (hit) begin
                    cnt_q <= cnt_d;
                    sat_q <= (cnt_d == CNT_MAX);
                end
            end
        end
    end

    assign z           = z_q;
    assign match_count = cnt_q;
    assign count_sat   = sat_q;
    assign cfg_err     = err_q;

endmodule
